// File: rtl/reg_bus_master_pkg.sv
// Shared encodings for the register-bus initiator: FSM states, block-select field
// position and the read latencies the initiator knows how to time.
package reg_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_WR       = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RD_HOLD  = 3'd5,
    ST_FINISH   = 3'd6
  } state_e;

  localparam int BLOCK_SEL_MSB = 7;
  localparam int BLOCK_SEL_LSB = 6;

  localparam int READ_LATENCY_COMB = 0;
  localparam int READ_LATENCY_REG  = 1;

  function automatic logic [1:0] block_sel(input logic [7:0] addr);
    return addr[BLOCK_SEL_MSB:BLOCK_SEL_LSB];
  endfunction

endpackage

// File: rtl/reg_bus_master.sv
// Initiator end of the 8-bit register bus: turns one command plus a byte stream
// into a burst of byte-wise register strobes with an incrementing byte count.
module reg_bus_master
  import reg_bus_master_pkg::*;
#(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pREAD_LATENCY = 1
) (
  input  logic                     usb_clk,
  input  logic                     reset_i,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [7:0]               cmd_address,
  input  logic [pBYTECNT_SIZE-1:0] cmd_len,
  input  logic                     cmd_abort,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [7:0]               reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               write_data,
  input  logic [7:0]               read_data,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic                     reg_addrvalid,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted
);

  localparam bit COMB_SLAVE = (pREAD_LATENCY == READ_LATENCY_COMB);

  state_e                   state_q;
  logic                     write_q;
  logic                     last_q;
  logic [pBYTECNT_SIZE-1:0] len_q;
  logic [pBYTECNT_SIZE-1:0] idx_q;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt_q;
  logic [7:0]               reg_address_q;
  logic [7:0]               write_data_q;
  logic [7:0]               rd_data_q;
  logic                     reg_read_q;
  logic                     reg_write_q;
  logic                     reg_addrvalid_q;
  logic                     rd_valid_q;
  logic                     done_q;
  logic                     aborted_q;
  logic                     abort_hit;

  // FINISH is already winding down, so an abort there has nothing left to cancel.
  assign abort_hit = cmd_abort && (state_q != ST_IDLE) && (state_q != ST_FINISH);

  assign cmd_ready     = (state_q == ST_IDLE) && !reset_i;
  assign wr_ready      = (state_q == ST_WR) && !last_q && !cmd_abort && !reset_i;
  assign busy          = (state_q != ST_IDLE);
  assign reg_address   = reg_address_q;
  assign reg_bytecnt   = reg_bytecnt_q;
  assign write_data    = write_data_q;
  assign reg_read      = reg_read_q;
  assign reg_write     = reg_write_q;
  assign reg_addrvalid = reg_addrvalid_q;
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign done          = done_q;
  assign aborted       = aborted_q;

  always_ff @(posedge usb_clk) begin
    if (reset_i) begin
      state_q         <= ST_IDLE;
      write_q         <= 1'b0;
      last_q          <= 1'b0;
      len_q           <= '0;
      idx_q           <= '0;
      reg_bytecnt_q   <= '0;
      reg_address_q   <= '0;
      write_data_q    <= '0;
      rd_data_q       <= '0;
      reg_read_q      <= 1'b0;
      reg_write_q     <= 1'b0;
      reg_addrvalid_q <= 1'b0;
      rd_valid_q      <= 1'b0;
      done_q          <= 1'b0;
      aborted_q       <= 1'b0;
    end else begin
      // Strobes and completion flags are single-cycle unless re-armed below.
      reg_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      if (abort_hit) begin
        state_q         <= ST_FINISH;
        reg_addrvalid_q <= 1'b0;
        rd_valid_q      <= 1'b0;
        done_q          <= 1'b1;
        aborted_q       <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (cmd_valid) begin
              state_q         <= ST_SETUP;
              reg_address_q   <= cmd_address;
              reg_addrvalid_q <= 1'b1;
              len_q           <= cmd_len;
              write_q         <= cmd_write;
              idx_q           <= '0;
              last_q          <= 1'b0;
              reg_bytecnt_q   <= '0;
            end
          end
          ST_SETUP: begin
            if (write_q) begin
              state_q <= ST_WR;
            end else begin
              state_q       <= ST_RD_ISSUE;
              reg_read_q    <= 1'b1;
              reg_bytecnt_q <= idx_q;
            end
          end
          ST_WR: begin
            // last_q lets the final strobe complete before leaving, and avoids
            // the index wrapping on a full-length burst.
            if (last_q) begin
              state_q         <= ST_FINISH;
              reg_addrvalid_q <= 1'b0;
              done_q          <= 1'b1;
            end else if (wr_valid) begin
              reg_write_q   <= 1'b1;
              write_data_q  <= wr_data;
              reg_bytecnt_q <= idx_q;
              if (idx_q == len_q) last_q <= 1'b1;
              else                idx_q  <= idx_q + 1'b1;
            end
          end
          ST_RD_ISSUE: begin
            if (COMB_SLAVE) begin
              rd_data_q  <= read_data;
              rd_valid_q <= 1'b1;
              state_q    <= ST_RD_HOLD;
            end else begin
              state_q <= ST_RD_WAIT;
            end
          end
          ST_RD_WAIT: begin
            rd_data_q  <= read_data;
            rd_valid_q <= 1'b1;
            state_q    <= ST_RD_HOLD;
          end
          ST_RD_HOLD: begin
            if (rd_ready) begin
              rd_valid_q <= 1'b0;
              if (idx_q == len_q) begin
                state_q         <= ST_FINISH;
                reg_addrvalid_q <= 1'b0;
                done_q          <= 1'b1;
              end else begin
                idx_q         <= idx_q + 1'b1;
                reg_bytecnt_q <= idx_q + 1'b1;
                reg_read_q    <= 1'b1;
                state_q       <= ST_RD_ISSUE;
              end
            end
          end
          ST_FINISH: state_q <= ST_IDLE;
          default:   state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: a table of bursts against a registered slave,
// plus hand-written reset, busy-ignore and combinational-slave sequences.
module tb_reg_bus_master;
  import reg_bus_master_pkg::*;

  logic       usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  logic       reset_i;
  // registered-slave instance
  logic       cmd_valid, cmd_ready, cmd_write, cmd_abort;
  logic [7:0] cmd_address;
  logic [6:0] cmd_len;
  logic [7:0] wr_data, rd_data, reg_address, write_data, read_data;
  logic       wr_valid, wr_ready, rd_valid, rd_ready;
  logic [6:0] reg_bytecnt;
  logic       reg_read, reg_write, reg_addrvalid, busy, done, aborted;
  // combinational-slave instance
  logic       cmd_valid0, cmd_ready0, cmd_write0, cmd_abort0;
  logic [7:0] cmd_address0;
  logic [6:0] cmd_len0;
  logic [7:0] wr_data0, rd_data0, reg_address0, write_data0, read_data0;
  logic       wr_valid0, wr_ready0, rd_valid0, rd_ready0;
  logic [6:0] reg_bytecnt0;
  logic       reg_read0, reg_write0, reg_addrvalid0, busy0, done0, aborted0;

  logic [7:0] mem [128];

  reg_bus_master #(.pBYTECNT_SIZE(7), .pREAD_LATENCY(READ_LATENCY_REG)) dut (
    .usb_clk(usb_clk), .reset_i(reset_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_len(cmd_len), .cmd_abort(cmd_abort),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .write_data(write_data),
    .read_data(read_data), .reg_read(reg_read), .reg_write(reg_write),
    .reg_addrvalid(reg_addrvalid), .busy(busy), .done(done), .aborted(aborted));

  reg_bus_master #(.pBYTECNT_SIZE(7), .pREAD_LATENCY(READ_LATENCY_COMB)) dut0 (
    .usb_clk(usb_clk), .reset_i(reset_i),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write0),
    .cmd_address(cmd_address0), .cmd_len(cmd_len0), .cmd_abort(cmd_abort0),
    .wr_data(wr_data0), .wr_valid(wr_valid0), .wr_ready(wr_ready0),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_ready(rd_ready0),
    .reg_address(reg_address0), .reg_bytecnt(reg_bytecnt0), .write_data(write_data0),
    .read_data(read_data0), .reg_read(reg_read0), .reg_write(reg_write0),
    .reg_addrvalid(reg_addrvalid0), .busy(busy0), .done(done0), .aborted(aborted0));

  // Slave models: one registered (data the cycle after reg_read), one combinational.
  always @(posedge usb_clk) if (reg_read) read_data <= mem[reg_bytecnt];
  assign read_data0 = reg_read0 ? mem[reg_bytecnt0] : 8'h00;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor on the registered-slave instance; per-burst counters clear while idle.
  logic [7:0] cur_addr = 8'h00;
  logic [7:0] stream_base = 8'h00;
  int cyc = 0, wr_cnt = 0, rd_pulses = 0, first_wr = 0, last_wr = 0;
  int seq_bad = 0, proto_bad = 0, done_cnt = 0;

  always @(negedge usb_clk) begin
    cyc++;
    if (busy !== 1'b1) begin
      wr_cnt    = 0;
      rd_pulses = 0;
    end else begin
      if (reg_write) begin
        if (reg_bytecnt != 7'(wr_cnt) || write_data != 8'(stream_base + wr_cnt)) seq_bad++;
        if (wr_cnt == 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
      end
      if (reg_read) begin
        if (reg_bytecnt != 7'(rd_pulses)) seq_bad++;
        rd_pulses++;
      end
    end
    if ((reg_read || reg_write) && (!reg_addrvalid || reg_address != cur_addr)) proto_bad++;
    if (reg_read && reg_write) proto_bad++;
    if (done) done_cnt++;
  end

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [6:0] len;
    logic [7:0] base;
    int         abort_after;
    logic       toggle;
    int         exp_xfers;
    int         exp_pulses;
    logic       exp_aborted;
  } vec_t;

  vec_t vecs [8];

  task automatic issue(input logic w, input logic [7:0] a, input logic [6:0] l, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge usb_clk); #1;
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("cmd_ready_timeout", 32'd0, 32'd1);
      return;
    end
    cur_addr = a;
    cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_len = l;
    @(negedge usb_clk); #1;
    cmd_valid = 1'b0;
    chk("setup_addrvalid", reg_addrvalid, 1);
    chk("setup_address", reg_address, a);
    chk("setup_no_strobe", reg_read | reg_write, 0);
    chk("setup_busy", busy, 1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int xfers = 0, iter = 0, d0 = done_cnt, s0 = seq_bad, p0 = proto_bad;
    bit sent = 0, got_done = 0, ok;
    stream_base = v.base;
    issue(v.wr, v.addr, v.len, ok);
    if (!ok) return;
    while (iter < 400) begin
      @(negedge usb_clk); #1;
      if (done) begin got_done = 1; break; end
      cmd_abort = (v.abort_after >= 0) && (xfers == v.abort_after) && !sent;
      if (cmd_abort) sent = 1;
      if (v.wr) begin wr_valid = 1'b1; wr_data = 8'(v.base + xfers); end
      else rd_ready = v.toggle ? iter[0] : 1'b1;
      #1;
      if (v.wr && wr_valid && wr_ready) xfers++;
      if (!v.wr && rd_valid && rd_ready && !cmd_abort) begin
        chk("rd_data", rd_data, mem[xfers]);
        xfers++;
      end
      iter++;
    end
    cmd_abort = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    chk("done_seen", got_done, 1);
    chk("done_aborted", aborted, v.exp_aborted);
    chk("done_addrvalid_low", reg_addrvalid, 0);
    chk("done_strobes_low", reg_read | reg_write, 0);
    chk("done_rd_valid_low", rd_valid, 0);
    chk("xfers", xfers, v.exp_xfers);
    if (v.wr) chk("wr_strobes", wr_cnt, v.exp_xfers);
    else      chk("rd_pulses", rd_pulses, v.exp_pulses);
    if (v.wr && !v.exp_aborted) begin
      chk("done_after_last_wr", cyc, last_wr + 1);
      chk("wr_back_to_back", last_wr - first_wr, v.len);
    end
    chk("bytecnt_data_seq", seq_bad - s0, 0);
    chk("addr_stable_no_overlap", proto_bad - p0, 0);
    @(negedge usb_clk); #1;
    chk("cmd_ready_after", cmd_ready, 1);
    chk("done_one_pulse", done_cnt - d0, 1);
    $display("vec %0d: %s addr=0x%02h blk=%0d len=%0d xfers=%0d aborted=%0b",
             id, v.wr ? "WR" : "RD", v.addr, block_sel(v.addr), v.len, xfers, aborted);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int xf, d0;
    vec_t rv;

    mem[0] = 8'h41; mem[1] = 8'h72; mem[2] = 8'h6d; mem[3] = 8'h54;
    mem[4] = 8'h72; mem[5] = 8'h61; mem[6] = 8'h63; mem[7] = 8'h65;
    for (int i = 8; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;

    //            wr    addr   len    base   abort tog  xfers pulses aborted
    vecs[0] = '{1'b1, 8'h05, 7'd7,   8'h00, -1, 1'b0, 8,   0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 7'd7,   8'h00, -1, 1'b0, 8,   8, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 7'd7,   8'h00, -1, 1'b1, 8,   8, 1'b0};
    vecs[3] = '{1'b1, 8'h2C, 7'd0,   8'hA5, -1, 1'b0, 1,   0, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 7'd7,   8'h00,  3, 1'b0, 3,   4, 1'b1};
    vecs[5] = '{1'b1, 8'hC3, 7'd127, 8'h10, -1, 1'b0, 128, 0, 1'b0};
    vecs[6] = '{1'b1, 8'h40, 7'd7,   8'h20,  2, 1'b0, 2,   0, 1'b1};
    vecs[7] = '{1'b0, 8'h80, 7'd0,   8'h00, -1, 1'b0, 1,   1, 1'b0};

    reset_i = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_address = 0; cmd_len = 0; cmd_abort = 0;
    wr_data = 0; wr_valid = 0; rd_ready = 0;
    cmd_valid0 = 0; cmd_write0 = 0; cmd_address0 = 0; cmd_len0 = 0; cmd_abort0 = 0;
    wr_data0 = 0; wr_valid0 = 0; rd_ready0 = 0;

    repeat (3) @(negedge usb_clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outputs", {reg_read, reg_write, reg_addrvalid, rd_valid, done, aborted}, 0);
    chk("rst_buses", {reg_address, reg_bytecnt, write_data, rd_data}, 0);
    chk("rst_dut0_outputs", {reg_read0, reg_write0, reg_addrvalid0, rd_valid0, done0, busy0, wr_ready0}, 0);
    reset_i = 1'b0;
    @(negedge usb_clk); #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    $display("reset: cmd_ready=%0b busy=%0b", cmd_ready, busy);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset in the middle of a write burst.
    d0 = done_cnt;
    stream_base = 8'h30;
    issue(1'b1, 8'h11, 7'd7, ok);
    xf = 0;
    for (int i = 0; i < 10 && xf < 3; i++) begin
      @(negedge usb_clk); #1;
      wr_valid = 1'b1; wr_data = 8'(8'h30 + xf);
      #1;
      if (wr_ready) xf++;
    end
    @(negedge usb_clk); #1;
    wr_valid = 1'b0;
    reset_i = 1'b1;
    @(negedge usb_clk); #1;
    chk("midrst_strobes", {reg_read, reg_write, reg_addrvalid}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_done", done, 0);
    reset_i = 1'b0;
    @(negedge usb_clk); #1;
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_cmd_ready_release", cmd_ready, 1);
    $display("midburst reset: %0d bytes accepted before reset, done pulses=%0d", xf, done_cnt - d0);
    rv = '{1'b1, 8'h2C, 7'd0, 8'hA5, -1, 1'b0, 1, 0, 1'b0};
    run_vec(rv, 8);

    // cmd_valid while busy is ignored; rd_data holds; abort beats a coincident rd_ready.
    issue(1'b0, 8'h80, 7'd3, ok);
    rd_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 8'h3F; cmd_len = 7'd0;
    repeat (4) @(negedge usb_clk);
    #1;
    cmd_valid = 1'b0;
    chk("busy_ignore_addr", reg_address, 8'h80);
    chk("busy_ignore_no_write", reg_write, 0);
    chk("busy_hold_valid", rd_valid, 1);
    chk("busy_hold_data", rd_data, mem[0]);
    chk("busy_no_extra_read", rd_pulses, 1);
    cmd_abort = 1'b1; rd_ready = 1'b1;
    @(negedge usb_clk); #1;
    cmd_abort = 1'b0; rd_ready = 1'b0;
    chk("abort_hold_done", done, 1);
    chk("abort_hold_aborted", aborted, 1);
    chk("abort_hold_rd_valid", rd_valid, 0);
    @(negedge usb_clk); #1;
    chk("abort_hold_cmd_ready", cmd_ready, 1);
    $display("busy-ignore/abort-in-hold: addr=0x%02h rd_pulses=%0d", cur_addr, rd_pulses);

    // Combinational slave: each byte captured in its own reg_read cycle.
    cmd_valid0 = 1'b1; cmd_write0 = 1'b0; cmd_address0 = 8'h00; cmd_len0 = 7'd1;
    @(negedge usb_clk); #1;
    cmd_valid0 = 1'b0;
    chk("l0_setup", {reg_addrvalid0, reg_read0}, 2'b10);
    @(negedge usb_clk); #1;
    chk("l0_read0", {reg_read0, reg_bytecnt0}, {1'b1, 7'd0});
    @(negedge usb_clk); #1;
    chk("l0_valid0", {rd_valid0, rd_data0, reg_read0}, {1'b1, 8'h41, 1'b0});
    @(negedge usb_clk); #1;
    chk("l0_hold0", {rd_valid0, rd_data0, reg_read0}, {1'b1, 8'h41, 1'b0});
    rd_ready0 = 1'b1;
    @(negedge usb_clk); #1;
    rd_ready0 = 1'b0;
    chk("l0_read1", {reg_read0, reg_bytecnt0, rd_valid0}, {1'b1, 7'd1, 1'b0});
    @(negedge usb_clk); #1;
    chk("l0_valid1", {rd_valid0, rd_data0}, {1'b1, 8'h72});
    rd_ready0 = 1'b1;
    @(negedge usb_clk); #1;
    rd_ready0 = 1'b0;
    chk("l0_done", {done0, aborted0, reg_addrvalid0}, 3'b100);
    @(negedge usb_clk); #1;
    chk("l0_cmd_ready", cmd_ready0, 1);
    $display("latency0 read: len=1 done=%0b", done0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
